serv_decode_queue: RTL

// Buffered pre-decode stage between ibus and core. Accepts 32-bit instruction words over valid/ready and

---
 rtl/serv_decode_queue.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/serv_decode_queue.sv
// Buffered pre-decode queue between ibus and core: words are decoded on write and held in a DEPTH-entry ring.
// Optional macro SERV_DECODE_ILLEGAL_EN stores a per-entry illegal-instruction flag driven on o_illegal.
module serv_decode_queue #(
    parameter int DEPTH = 2,
    parameter bit MDU   = 1'b0,
    parameter bit CSR   = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_ibus_rdt,
    input  logic        i_ibus_valid,
    output logic        o_ibus_ready,
    input  logic        i_flush,
    input  logic        i_en,
    output logic        o_valid,
    output logic [4:0]  o_opcode,
    output logic [2:0]  o_funct3,
    output logic [4:0]  o_rd,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2,
    output logic        o_imm30,
    output logic        o_branch_op,
    output logic        o_cond_branch,
    output logic        o_mem_cmd,
    output logic        o_dbus_en,
    output logic        o_shift_op,
    output logic        o_rd_op,
    output logic        o_mdu_op,
    output logic        o_csr_op,
    output logic        o_illegal
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [4:0] opcode;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       imm30;
        logic       branch_op;
        logic       cond_branch;
        logic       mem_cmd;
        logic       dbus_en;
        logic       shift_op;
        logic       rd_op;
        logic       mdu_op;
        logic       csr_op;
`ifdef SERV_DECODE_ILLEGAL_EN
        logic       illegal;
`endif
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          wr_ent;
    entry_t          head;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [4:0]      op;
    logic [2:0]      f3;
    logic            wr;
    logic            rd;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign op = i_ibus_rdt[6:2];
    assign f3 = i_ibus_rdt[14:12];

    always_comb begin
        wr_ent             = '0;
        wr_ent.opcode      = op;
        wr_ent.funct3      = f3;
        wr_ent.rd          = i_ibus_rdt[11:7];
        wr_ent.rs1         = i_ibus_rdt[19:15];
        wr_ent.rs2         = i_ibus_rdt[24:20];
        wr_ent.imm30       = i_ibus_rdt[30];
        wr_ent.branch_op   = op[0] | op[4];
        wr_ent.cond_branch = op[4] & ~op[0];
        wr_ent.mem_cmd     = op[3];
        wr_ent.dbus_en     = (~op[2] & ~op[4]) | (~|f3 & ~op[4]);
        wr_ent.shift_op    = (op[0] & ~op[4]) | (op[2] & ~f3[1]);
        wr_ent.rd_op       = op[0] | op[2] | ~op[3];
        wr_ent.mdu_op      = MDU & (op == 5'b01100) & i_ibus_rdt[25];
        wr_ent.csr_op      = CSR & op[4] & op[2] & (|f3);
`ifdef SERV_DECODE_ILLEGAL_EN
        case (op)
            5'b00000, 5'b00011, 5'b00100, 5'b00101, 5'b01000, 5'b01100,
            5'b01101, 5'b11000, 5'b11001, 5'b11011, 5'b11100: wr_ent.illegal = 1'b0;
            default:                                          wr_ent.illegal = 1'b1;
        endcase
        // M-ext and SYSTEM words are only legal when the matching unit is built in
        if (i_ibus_rdt[1:0] != 2'b11)                          wr_ent.illegal = 1'b1;
        if (!MDU && op == 5'b01100 && i_ibus_rdt[25])          wr_ent.illegal = 1'b1;
        if (!CSR && op == 5'b11100)                            wr_ent.illegal = 1'b1;
`endif
    end

    logic unused_rdt;
`ifdef SERV_DECODE_ILLEGAL_EN
    assign unused_rdt = ^{i_ibus_rdt[31], i_ibus_rdt[29:26]};
`else
    assign unused_rdt = ^{i_ibus_rdt[31], i_ibus_rdt[29:26], i_ibus_rdt[1:0]};
`endif

    assign o_ibus_ready = (count != CW'(DEPTH));
    assign o_valid      = (count != '0);
    assign wr           = i_ibus_valid & o_ibus_ready;
    assign rd           = i_en & o_valid;

    // Flush and reset both collapse the ring; flush also drops the word offered with it
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr) wr_ptr <= ptr_inc(wr_ptr);
            if (rd) rd_ptr <= ptr_inc(rd_ptr);
            if (wr && !rd)      count <= count + 1'b1;
            else if (rd && !wr) count <= count - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr) mem[wr_ptr] <= wr_ent;
    end

    assign head = o_valid ? mem[rd_ptr] : '0;

    assign o_opcode      = head.opcode;
    assign o_funct3      = head.funct3;
    assign o_rd          = head.rd;
    assign o_rs1         = head.rs1;
    assign o_rs2         = head.rs2;
    assign o_imm30       = head.imm30;
    assign o_branch_op   = head.branch_op;
    assign o_cond_branch = head.cond_branch;
    assign o_mem_cmd     = head.mem_cmd;
    assign o_dbus_en     = head.dbus_en;
    assign o_shift_op    = head.shift_op;
    assign o_rd_op       = head.rd_op;
    assign o_mdu_op      = head.mdu_op;
    assign o_csr_op      = head.csr_op;
`ifdef SERV_DECODE_ILLEGAL_EN
    assign o_illegal     = head.illegal;
`else
    assign o_illegal     = 1'b0;
`endif

endmodule
